multicycle_control: RTL and testbench

Multicycle control unit for the 16-bit MicroProcessor datapath, sitting directly upstream of the ALU. It sequences each instruction through fetch/decode/execute/memory/writeback states, drives the ALU opcode and operand selects, and consumes the ALU `isZero` flag to resolve branches. It also drives the datapath write strobes and keeps a retired-instruction counter.

---
 rtl/multicycle_control.sv | 107 ++++++++++
 tb/tb_multicycle_control.sv | 118 +++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle FSM sequencing fetch/decode/execute/memory/writeback for the 16-bit datapath.
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        isZero,
  output logic [2:0]  ALUcontrol,
  output logic        ALUsrcA,
  output logic [1:0]  ALUsrcB,
  output logic        PCwrite,
  output logic        IRwrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [1:0]  PCsrc,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] instret
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP} state_t;
  state_t cur, nxt;
  logic [3:0] op;
  logic rtype, lw, sw, beq, jmp, retire;
  assign op    = instr[15:12];
  assign rtype = ~op[3];
  assign lw    = op == 4'b1001;
  assign sw    = op == 4'b1010;
  assign beq   = op == 4'b1011;
  assign jmp   = op == 4'b1100;
  assign state = cur;
  assign retire = cur == WB || (cur == MEM && sw) || cur == BRANCH || cur == JUMP;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur     <= FETCH;
      instret <= 16'd0;
    end else begin
      cur     <= nxt;
      instret <= instret + {15'd0, retire};
    end
  end
  always_comb begin
    nxt        = FETCH;
    ALUcontrol = 3'b000;
    ALUsrcA    = 1'b0;
    ALUsrcB    = 2'b00;
    PCwrite    = 1'b0;
    IRwrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    PCsrc      = 2'b00;
    illegal    = 1'b0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        IRwrite = 1'b1;
        ALUsrcB = 2'b01;
        PCwrite = 1'b1;
        nxt     = DECODE;
      end
      DECODE: begin
        ALUsrcB = 2'b10;
        nxt     = beq ? BRANCH : jmp ? JUMP : op[3:2] == 2'b11 ? FETCH : EXEC;
        illegal = op[3:2] == 2'b11 && !jmp;
      end
      EXEC: begin
        ALUsrcA    = 1'b1;
        ALUsrcB    = rtype ? 2'b00 : 2'b10;
        ALUcontrol = rtype ? op[2:0] : 3'b000;
        nxt        = lw || sw ? MEM : WB;
      end
      MEM: begin
        IorD     = 1'b1;
        MemRead  = lw;
        MemWrite = sw;
        nxt      = lw ? WB : FETCH;
      end
      WB: begin
        RegWrite = 1'b1;
        MemToReg = lw;
      end
      BRANCH: begin
        ALUsrcA    = 1'b1;
        ALUcontrol = 3'b001;
        PCsrc      = 2'b01;
        PCwrite    = isZero;
      end
      JUMP: begin
        PCsrc   = 2'b10;
        PCwrite = 1'b1;
      end
      default: nxt = FETCH;
    endcase
    if (!rst_n) begin
      PCwrite  = 1'b0;
      IRwrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vectors through every instruction class, reset mid-store and counter wrap.
module tb_multicycle_control;
  logic clk = 1'b0, rst_n, isZero;
  logic [15:0] instr, instret;
  logic [2:0] ALUcontrol, state;
  logic [1:0] ALUsrcB, PCsrc;
  logic ALUsrcA, PCwrite, IRwrite, MemRead, MemWrite, IorD, RegWrite, MemToReg, illegal;
  logic [18:0] ctrl;
  int tests = 0, fails = 0;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .isZero(isZero),
    .ALUcontrol(ALUcontrol), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
    .PCwrite(PCwrite), .IRwrite(IRwrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .RegWrite(RegWrite), .MemToReg(MemToReg), .PCsrc(PCsrc),
    .illegal(illegal), .state(state), .instret(instret)
  );
  always #5 clk = ~clk;
  assign ctrl = {state, ALUcontrol, ALUsrcA, ALUsrcB, PCwrite, IRwrite, MemRead, MemWrite,
                 IorD, RegWrite, MemToReg, PCsrc, illegal};
  function automatic logic [18:0] c(input logic [2:0] st, input logic [2:0] alu, input logic a,
      input logic [1:0] b, input logic pw, iw, mr, mw, iod, rw, m2r, input logic [1:0] pcs,
      input logic ill);
    return {st, alu, a, b, pw, iw, mr, mw, iod, rw, m2r, pcs, ill};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic put(input logic [15:0] v);
    instr = v;
    #1;
  endtask
  logic [18:0] f, d, ei, wb;
  initial begin
    f  = c(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    d  = c(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ei = c(2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb = c(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    rst_n = 1'b0; isZero = 1'b0; instr = 16'h0000;
    cyc(); cyc();
    check("rst_ctrl", ctrl, c(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_instret", instret, 0);
    rst_n = 1'b1;
    put(16'h6A50);
    check("x_fetch", ctrl, f);
    cyc(); check("x_dec", ctrl, d);
    cyc(); check("x_exec", ctrl, c(2, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); check("x_wb", ctrl, wb);
    check("x_instret_pre", instret, 0);
    cyc(); check("x_next", ctrl, f);
    check("x_instret", instret, 1);
    put(16'h9283);
    cyc(); check("lw_dec", ctrl, d);
    cyc(); check("lw_exec", ctrl, ei);
    cyc(); check("lw_mem", ctrl, c(3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    cyc(); check("lw_wb", ctrl, c(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    cyc(); check("lw_next", ctrl, f);
    check("lw_instret", instret, 2);
    put(16'hB283);
    cyc(); check("beq1_dec", ctrl, d);
    cyc(); isZero = 1'b1; #1;
    check("beq1_br", ctrl, c(5, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    isZero = 1'b0; #1;
    check("beq_mealy", PCwrite, 0);
    cyc(); check("beq1_next", ctrl, f);
    check("beq1_instret", instret, 3);
    cyc(); check("beq0_dec", ctrl, d);
    cyc(); check("beq0_br", ctrl, c(5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc(); check("beq0_next", ctrl, f);
    check("beq0_instret", instret, 4);
    put(16'hE000);
    cyc(); check("ill_dec", ctrl, c(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(); check("ill_next", ctrl, f);
    check("ill_instret", instret, 4);
    put(16'hC123);
    cyc(); check("jmp_dec", ctrl, d);
    cyc(); check("jmp_jump", ctrl, c(6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0));
    cyc(); check("jmp_next", ctrl, f);
    check("jmp_instret", instret, 5);
    put(16'hA283);
    cyc(); check("sw_dec", ctrl, d);
    cyc(); check("sw_exec", ctrl, ei);
    cyc(); check("sw_mem", ctrl, c(3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    cyc(); check("sw_next", ctrl, f);
    check("sw_instret", instret, 6);
    put(16'h8283);
    cyc(); check("addi_dec", ctrl, d);
    cyc(); check("addi_exec", ctrl, ei);
    cyc(); check("addi_wb", ctrl, wb);
    cyc(); check("addi_next", ctrl, f);
    check("addi_instret", instret, 7);
    put(16'hA283);
    cyc(); cyc(); cyc();
    check("rsw_mem", state, 3);
    rst_n = 1'b0; #1;
    check("rsw_gate", ctrl, c(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    cyc(); rst_n = 1'b1; #1;
    check("rsw_fetch", ctrl, f);
    check("rsw_instret", instret, 0);
    put(16'h8283);
    force dut.instret = 16'hFFFF;
    cyc(); release dut.instret; #1;
    check("wrap_dec", ctrl, d);
    check("wrap_preset", instret, 16'hFFFF);
    cyc(); cyc(); check("wrap_wb", instret, 16'hFFFF);
    cyc(); check("wrap_next", ctrl, f);
    check("wrap_instret", instret, 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
